// File: rtl/lock_pkg.sv
// Shared types and default constants for the canal lock controller.
package lock_pkg;

    // Controller states; encodings are visible on the state output.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARRIVING  = 3'd1,
        ST_POUND     = 3'd2,
        ST_DEPARTING = 3'd3
    } lock_state_t;

    // Gondola direction: IN arrives from the outer side, OUT from the inner side.
    typedef enum logic {
        DIR_IN  = 1'b0,
        DIR_OUT = 1'b1
    } lock_dir_t;

    // One bit per operator switch, used for edge detection as a group.
    typedef struct packed {
        logic drain;
        logic fill;
        logic outer_door;
        logic inner_door;
        logic outer_arr;
        logic inner_arr;
    } lock_sw_t;

    // Default water levels and steps, in 1/16 ft.
    localparam int DEF_INNER_LVL  = 80;
    localparam int DEF_OUTER_LVL  = 0;
    localparam int DEF_TOL        = 5;
    localparam int DEF_FILL_STEP  = 10;
    localparam int DEF_DRAIN_STEP = 11;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lock_water_level.sv
// Lock chamber water level: saturating fill/drain, door-openable flags and,
// when LOCK_AUTO_PUMP_EN is defined, automatic pumping while the gondola is
// in the pound.
module lock_water_level
    import lock_pkg::*;
#(
    parameter int LVL_W      = 12,
    parameter int INNER_LVL  = DEF_INNER_LVL,
    parameter int OUTER_LVL  = DEF_OUTER_LVL,
    parameter int TOL        = DEF_TOL,
    parameter int FILL_STEP  = DEF_FILL_STEP,
    parameter int DRAIN_STEP = DEF_DRAIN_STEP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fill_edge,
    input  logic             drain_edge,
    input  logic             tick,
    input  logic             pump_en,
    input  logic             pump_to_inner,
    output logic [LVL_W-1:0] level,
    output logic             inner_openable,
    output logic             outer_openable
);

    // Everything is evaluated one bit wider so saturation never wraps.
    localparam logic [LVL_W:0] INNER_X = (LVL_W+1)'(INNER_LVL);
    localparam logic [LVL_W:0] OUTER_X = (LVL_W+1)'(OUTER_LVL);
    localparam logic [LVL_W:0] TOL_X   = (LVL_W+1)'(TOL);
    localparam logic [LVL_W:0] FILL_X  = (LVL_W+1)'(FILL_STEP);
    localparam logic [LVL_W:0] DRAIN_X = (LVL_W+1)'(DRAIN_STEP);

    logic [LVL_W:0]   lvl_x;
    logic [LVL_W:0]   fill_sum;
    logic [LVL_W:0]   drain_diff;
    logic [LVL_W-1:0] filled;
    logic [LVL_W-1:0] drained;
    logic [LVL_W-1:0] level_n;

    assign lvl_x      = {1'b0, level};
    assign fill_sum   = lvl_x + FILL_X;
    assign drain_diff = lvl_x - DRAIN_X;
    assign filled     = (fill_sum > INNER_X) ? INNER_X[LVL_W-1:0] : fill_sum[LVL_W-1:0];
    assign drained    = (lvl_x < OUTER_X + DRAIN_X) ? OUTER_X[LVL_W-1:0] : drain_diff[LVL_W-1:0];

    // level > INNER-TOL written as level+TOL > INNER to stay unsigned.
    assign outer_openable = (lvl_x < OUTER_X + TOL_X);
    assign inner_openable = (lvl_x + TOL_X > INNER_X);

    // Next level from operator requests (or the pump while in the pound).
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves level_n
        // unassigned, which would infer a latch.
        level_n = level;
`ifdef LOCK_AUTO_PUMP_EN
        if (pump_en) begin
            if (tick) level_n = pump_to_inner ? filled : drained;
        end else if (fill_edge && !drain_edge) begin
            level_n = filled;
        end else if (drain_edge && !fill_edge) begin
            level_n = drained;
        end
`else
        if (fill_edge && !drain_edge) begin
            level_n = filled;
        end else if (drain_edge && !fill_edge) begin
            level_n = drained;
        end
`endif
    end

`ifndef LOCK_AUTO_PUMP_EN
    // Pump controls have no effect when the pump feature is compiled out.
    logic pump_unused;
    assign pump_unused = ^{tick, pump_en, pump_to_inner};
`endif

    // Level register, reset to the outer (low) level.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!reset) level <= OUTER_X[LVL_W-1:0];
        else        level <= level_n;
    end

endmodule

// File: rtl/canal_lock_ctrl.sv
// Canal lock controller: sequences gondolas through arrival, pound and
// departure, queues arrivals that come while busy, and owns the water level.
// Build option: LOCK_AUTO_PUMP_EN enables automatic pumping in the pound.
module canal_lock_ctrl
    import lock_pkg::*;
#(
    parameter int LVL_W      = 12,
    parameter int INNER_LVL  = DEF_INNER_LVL,
    parameter int OUTER_LVL  = DEF_OUTER_LVL,
    parameter int TOL        = DEF_TOL,
    parameter int FILL_STEP  = DEF_FILL_STEP,
    parameter int DRAIN_STEP = DEF_DRAIN_STEP,
    parameter int ARR_DELAY  = 5,
    parameter int DEPT_DELAY = 5,
    parameter int TICK_DIV   = 1024,
    parameter int QDEPTH     = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        inner_arr_sw,
    input  logic                        outer_arr_sw,
    input  logic                        inner_door_sw,
    input  logic                        outer_door_sw,
    input  logic                        fill_sw,
    input  logic                        drain_sw,
    output logic [LVL_W-1:0]            water_level,
    output logic                        inner_openable,
    output logic                        outer_openable,
    output logic                        inner_gondola_led,
    output logic                        outer_gondola_led,
    output logic [2:0]                  state,
    output logic [$clog2(QDEPTH+1)-1:0] q_count,
    output logic                        err
);

    localparam int CNT_MAX = max_int(ARR_DELAY, DEPT_DELAY);
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam int DIV_W   = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
    localparam int QC_W    = $clog2(QDEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_MAX_C = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] ARR_C     = CNT_W'(ARR_DELAY);
    localparam logic [CNT_W-1:0] DEPT_C    = CNT_W'(DEPT_DELAY);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [QC_W-1:0]  QDEPTH_C  = QC_W'(QDEPTH);

    lock_sw_t         sw_now, sw_prev, rise;
    lock_state_t      st;
    lock_dir_t        dir;
    logic [CNT_W-1:0] cnt;
    logic [DIV_W-1:0] div;
    logic             tick;

    lock_dir_t        q   [QDEPTH];
    lock_dir_t        q_n [QDEPTH];
    logic [QC_W-1:0]  q_cnt, q_cnt_n;
    logic             q_has, q_drop, pop, push_outer, push_inner;
    logic             idle_empty, dept_done, start;
    lock_dir_t        start_dir;
    logic             arr_door, dep_door, arr_open, dep_open;

    assign sw_now = '{drain: drain_sw, fill: fill_sw, outer_door: outer_door_sw,
                      inner_door: inner_door_sw, outer_arr: outer_arr_sw,
                      inner_arr: inner_arr_sw};
    assign rise   = sw_now & ~sw_prev;
    assign tick   = (div == DIV_LAST);

    // Door edges and openable flags seen from the current gondola's point of view.
    assign arr_door = (dir == DIR_IN) ? rise.outer_door : rise.inner_door;
    assign dep_door = (dir == DIR_IN) ? rise.inner_door : rise.outer_door;
    assign arr_open = (dir == DIR_IN) ? outer_openable  : inner_openable;
    assign dep_open = (dir == DIR_IN) ? inner_openable  : outer_openable;

    // Service/queue decisions: a queued gondola always goes ahead of a fresh edge.
    assign q_has      = (q_cnt != '0);
    assign idle_empty = (st == ST_IDLE) && !q_has;
    assign dept_done  = (st == ST_DEPARTING) && (cnt >= DEPT_C);
    assign start      = ((st == ST_IDLE) && (q_has || rise.outer_arr || rise.inner_arr))
                        || (dept_done && q_has);
    assign start_dir  = q_has ? q[0] : (rise.outer_arr ? DIR_IN : DIR_OUT);
    assign pop        = q_has && ((st == ST_IDLE) || dept_done);
    assign push_outer = rise.outer_arr && !idle_empty;
    assign push_inner = rise.inner_arr && !(idle_empty && !rise.outer_arr);

    // Edge registers follow the inputs in and out of reset alike.
    always_ff @(posedge clk) sw_prev <= sw_now;

    // Free-running tick divider.
    always_ff @(posedge clk) begin
        if (!reset)    div <= '0;
        else if (tick) div <= '0;
        else           div <= div + DIV_W'(1);
    end

    // Arrival queue next state: pop first, then outer before inner, dropping when full.
    always_comb begin
        q_n     = q;
        q_cnt_n = q_cnt;
        q_drop  = 1'b0;
        if (pop) begin
            for (int i = 0; i < QDEPTH - 1; i++) q_n[i] = q[i+1];
            q_cnt_n = q_cnt - QC_W'(1);
        end
        if (push_outer) begin
            if (q_cnt_n < QDEPTH_C) begin
                for (int i = 0; i < QDEPTH; i++) if (i == int'(q_cnt_n)) q_n[i] = DIR_IN;
                q_cnt_n = q_cnt_n + QC_W'(1);
            end else begin
                q_drop = 1'b1;
            end
        end
        if (push_inner) begin
            if (q_cnt_n < QDEPTH_C) begin
                for (int i = 0; i < QDEPTH; i++) if (i == int'(q_cnt_n)) q_n[i] = DIR_OUT;
                q_cnt_n = q_cnt_n + QC_W'(1);
            end else begin
                q_drop = 1'b1;
            end
        end
    end

    // Arrival queue registers.
    always_ff @(posedge clk) begin
        // NOTE: only the occupancy count is reset; entries beyond it are
        // never read, so the storage itself needs no reset.
        if (!reset) begin
            q_cnt <= '0;
        end else begin
            q_cnt <= q_cnt_n;
            q     <= q_n;
        end
    end

    // Gondola sequencing FSM with registered LEDs, tick counter and error pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            st                <= ST_IDLE;
            dir               <= DIR_IN;
            cnt               <= '0;
            inner_gondola_led <= 1'b0;
            outer_gondola_led <= 1'b0;
            err               <= 1'b0;
        end else begin
            err <= q_drop;
            if (tick && (cnt < CNT_MAX_C)) cnt <= cnt + CNT_W'(1);
            case (st)
                ST_IDLE: ;  // door edges ignored; starts handled below
                ST_ARRIVING: begin
                    if (arr_door) begin
                        if ((cnt >= ARR_C) && arr_open) begin
                            if (dir == DIR_IN) outer_gondola_led <= 1'b0;
                            else               inner_gondola_led <= 1'b0;
                            st <= ST_POUND;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_POUND: begin
                    if (dep_door) begin
                        if (dep_open) begin
                            if (dir == DIR_IN) inner_gondola_led <= 1'b1;
                            else               outer_gondola_led <= 1'b1;
                            cnt <= '0;
                            st  <= ST_DEPARTING;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_DEPARTING: begin
                    if (dept_done) begin
                        if (dir == DIR_IN) inner_gondola_led <= 1'b0;
                        else               outer_gondola_led <= 1'b0;
                        st <= ST_IDLE;
                    end
                end
                default: st <= ST_IDLE;
            endcase
            if (start) begin
                dir <= start_dir;
                cnt <= '0;
                st  <= ST_ARRIVING;
                if (start_dir == DIR_IN) outer_gondola_led <= 1'b1;
                else                     inner_gondola_led <= 1'b1;
            end
        end
    end

    lock_water_level #(
        .LVL_W(LVL_W), .INNER_LVL(INNER_LVL), .OUTER_LVL(OUTER_LVL), .TOL(TOL),
        .FILL_STEP(FILL_STEP), .DRAIN_STEP(DRAIN_STEP)
    ) u_level (
        .clk            (clk),
        .reset          (reset),
        .fill_edge      (rise.fill),
        .drain_edge     (rise.drain),
        .tick           (tick),
        .pump_en        (st == ST_POUND),
        .pump_to_inner  (dir == DIR_IN),
        .level          (water_level),
        .inner_openable (inner_openable),
        .outer_openable (outer_openable)
    );

    assign state   = st;
    assign q_count = q_cnt;

endmodule

// File: tb/tb_canal_lock_ctrl.sv
// Self-checking bench for canal_lock_ctrl (default build, TICK_DIV=4):
// directed scenarios with literal expectations, then random switching
// compared every cycle against a behavioural model.
module tb_canal_lock_ctrl;

    localparam int TICK_DIV = 4;
    localparam int QDEPTH   = 2;
    localparam int INNER    = 80;
    localparam int OUTER    = 0;
    localparam int TOL      = 5;
    localparam int FSTEP    = 10;
    localparam int DSTEP    = 11;
    localparam int ADELAY   = 5;
    localparam int DDELAY   = 5;

    // Switch bit positions
    localparam int B_IARR = 0, B_OARR = 1, B_IDOOR = 2, B_ODOOR = 3, B_FILL = 4, B_DRAIN = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  sw = '0;
    logic [11:0] water_level;
    logic        inner_openable, outer_openable, inner_gondola_led, outer_gondola_led, err;
    logic [2:0]  state;
    logic [1:0]  q_count;

    int n_checks = 0;
    int n_errors = 0;

    canal_lock_ctrl #(.TICK_DIV(TICK_DIV), .QDEPTH(QDEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .inner_arr_sw      (sw[B_IARR]),
        .outer_arr_sw      (sw[B_OARR]),
        .inner_door_sw     (sw[B_IDOOR]),
        .outer_door_sw     (sw[B_ODOOR]),
        .fill_sw           (sw[B_FILL]),
        .drain_sw          (sw[B_DRAIN]),
        .water_level       (water_level),
        .inner_openable    (inner_openable),
        .outer_openable    (outer_openable),
        .inner_gondola_led (inner_gondola_led),
        .outer_gondola_led (outer_gondola_led),
        .state             (state),
        .q_count           (q_count),
        .err               (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Direction codes: 0 = IN (from outer), 1 = OUT (from inner)
    bit       m_valid = 0;
    int       m_level, m_state, m_dir, m_ticks, m_phase;
    bit       m_in_led, m_out_led, m_err;
    bit [5:0] m_prev;
    int       mq[$];

    function automatic void serve(int d);
        m_dir   = d;
        m_ticks = 0;
        m_state = 1;
        if (d == 0) m_out_led = 1; else m_in_led = 1;
    endfunction

    always @(posedge clk) begin : model
        bit [5:0] e;
        bit tk, o_open, i_open, arr_door, dep_door, arr_open, dep_open;
        int old_ticks;
        int arrivals[$];
        if (!reset) begin
            m_level = OUTER; m_state = 0; m_dir = 0; m_ticks = 0; m_phase = 0;
            m_in_led = 0; m_out_led = 0; m_err = 0;
            mq.delete();
            m_valid = 1;
        end else begin
            e  = sw & ~m_prev;
            tk = (m_phase == TICK_DIV - 1);
            m_phase = (m_phase + 1) % TICK_DIV;
            old_ticks = m_ticks;
            o_open = (m_level < OUTER + TOL);
            i_open = (m_level > INNER - TOL);
            if (e[B_FILL] && !e[B_DRAIN])
                m_level = (m_level + FSTEP > INNER) ? INNER : m_level + FSTEP;
            else if (e[B_DRAIN] && !e[B_FILL])
                m_level = (m_level - DSTEP < OUTER) ? OUTER : m_level - DSTEP;
            if (tk && m_ticks < ((ADELAY > DDELAY) ? ADELAY : DDELAY)) m_ticks++;
            m_err = 0;
            arrivals.delete();
            if (e[B_OARR]) arrivals.push_back(0);
            if (e[B_IARR]) arrivals.push_back(1);
            arr_door = (m_dir == 0) ? e[B_ODOOR] : e[B_IDOOR];
            dep_door = (m_dir == 0) ? e[B_IDOOR] : e[B_ODOOR];
            arr_open = (m_dir == 0) ? o_open : i_open;
            dep_open = (m_dir == 0) ? i_open : o_open;
            case (m_state)
                0: begin
                    if (mq.size() > 0)            serve(mq.pop_front());
                    else if (arrivals.size() > 0) serve(arrivals.pop_front());
                end
                1: if (arr_door) begin
                    if (old_ticks >= ADELAY && arr_open) begin
                        if (m_dir == 0) m_out_led = 0; else m_in_led = 0;
                        m_state = 2;
                    end else m_err = 1;
                end
                2: if (dep_door) begin
                    if (dep_open) begin
                        if (m_dir == 0) m_in_led = 1; else m_out_led = 1;
                        m_ticks = 0;
                        m_state = 3;
                    end else m_err = 1;
                end
                default: if (old_ticks >= DDELAY) begin
                    if (m_dir == 0) m_in_led = 0; else m_out_led = 0;
                    if (mq.size() > 0) serve(mq.pop_front());
                    else m_state = 0;
                end
            endcase
            foreach (arrivals[i]) begin
                if (mq.size() < QDEPTH) mq.push_back(arrivals[i]);
                else m_err = 1;
            end
        end
        m_prev = sw;
    end

    // Per-cycle comparison against the model, half a clock after each edge
    always @(negedge clk) begin
        if (m_valid) begin
            check("cmp_level", int'(water_level), m_level);
            check("cmp_outer_open", int'(outer_openable), int'(m_level < OUTER + TOL));
            check("cmp_inner_open", int'(inner_openable), int'(m_level > INNER - TOL));
            check("cmp_state", int'(state), m_state);
            check("cmp_inner_led", int'(inner_gondola_led), int'(m_in_led));
            check("cmp_outer_led", int'(outer_gondola_led), int'(m_out_led));
            check("cmp_q_count", int'(q_count), mq.size());
            check("cmp_err", int'(err), int'(m_err));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rise(input logic [5:0] m);
        sw = sw | m;
        cyc(1);
    endtask

    task automatic fall(input logic [5:0] m);
        sw = sw & ~m;
        cyc(1);
    endtask

    task automatic press(input logic [5:0] m);
        rise(m);
        fall(m);
    endtask

    localparam logic [5:0] M_IARR  = 6'b000001;
    localparam logic [5:0] M_OARR  = 6'b000010;
    localparam logic [5:0] M_IDOOR = 6'b000100;
    localparam logic [5:0] M_ODOOR = 6'b001000;
    localparam logic [5:0] M_FILL  = 6'b010000;
    localparam logic [5:0] M_DRAIN = 6'b100000;

    initial begin
        // Reset held low for two cycles
        reset = 1'b0; sw = '0;
        cyc(2);
        check("rst_level", int'(water_level), 0);
        check("rst_outer_open", int'(outer_openable), 1);
        check("rst_inner_open", int'(inner_openable), 0);
        check("rst_state", int'(state), 0);
        check("rst_leds", int'({inner_gondola_led, outer_gondola_led}), 0);
        reset = 1'b1;
        cyc(1);

        // Fill to saturation, then one drain
        for (int k = 1; k <= 9; k++) begin
            press(M_FILL);
            check("fill_level", int'(water_level), (k * 10 > 80) ? 80 : k * 10);
            check("fill_inner_open", int'(inner_openable), (k >= 8) ? 1 : 0);
        end
        check("model_pin_80", m_level, 80);
        press(M_DRAIN);
        check("drain_level_69", int'(water_level), 69);
        check("drain_inner_open", int'(inner_openable), 0);
        repeat (7) press(M_DRAIN);
        check("drain_to_zero", int'(water_level), 0);

        // Outer arrival; door too early, then on time
        rise(M_OARR);
        check("arr_state", int'(state), 1);
        check("arr_outer_led", int'(outer_gondola_led), 1);
        fall(M_OARR);
        cyc(11);
        rise(M_ODOOR);
        check("early_door_err", int'(err), 1);
        check("early_door_state", int'(state), 1);
        check("model_pin_err", int'(m_err), 1);
        fall(M_ODOOR);
        cyc(10);
        rise(M_ODOOR);
        check("door_ok_state", int'(state), 2);
        check("door_ok_outer_led", int'(outer_gondola_led), 0);
        check("door_ok_err", int'(err), 0);
        fall(M_ODOOR);

        // Pound: fill, depart through inner door, finish to IDLE
        repeat (8) press(M_FILL);
        check("pound_level", int'(water_level), 80);
        rise(M_IDOOR);
        check("dep_state", int'(state), 3);
        check("dep_inner_led", int'(inner_gondola_led), 1);
        fall(M_IDOOR);
        cyc(15);
        check("dep_still", int'(state), 3);
        cyc(5);
        check("dep_done_state", int'(state), 0);
        check("dep_done_led", int'(inner_gondola_led), 0);

        // Inner arrival, then queue three arrivals during the pound
        rise(M_IARR);
        check("arr2_state", int'(state), 1);
        check("arr2_inner_led", int'(inner_gondola_led), 1);
        fall(M_IARR);
        cyc(24);
        rise(M_IDOOR);
        check("arr2_pound", int'(state), 2);
        fall(M_IDOOR);
        rise(M_IARR); check("q_one", int'(q_count), 1); fall(M_IARR);
        rise(M_IARR); check("q_two", int'(q_count), 2); fall(M_IARR);
        rise(M_IARR);
        check("q_full_err", int'(err), 1);
        check("q_full_count", int'(q_count), 2);
        fall(M_IARR);
        repeat (8) press(M_DRAIN);
        check("pound2_level", int'(water_level), 0);
        rise(M_ODOOR);
        check("dep2_state", int'(state), 3);
        check("dep2_outer_led", int'(outer_gondola_led), 1);
        fall(M_ODOOR);
        cyc(19);
        check("requeue_state", int'(state), 1);
        check("requeue_q", int'(q_count), 1);
        check("requeue_inner_led", int'(inner_gondola_led), 1);
        check("requeue_outer_led", int'(outer_gondola_led), 0);
        check("model_pin_q", mq.size(), 1);

        // Simultaneous fill and drain, then reset mid-operation
        repeat (4) press(M_FILL);
        check("lvl_40", int'(water_level), 40);
        press(M_FILL | M_DRAIN);
        check("fill_drain_40", int'(water_level), 40);
        repeat (4) press(M_FILL);
        cyc(24);
        rise(M_IDOOR);
        check("arr3_pound", int'(state), 2);
        fall(M_IDOOR);
        reset = 1'b0;
        cyc(1);
        check("midrst_state", int'(state), 0);
        check("midrst_q", int'(q_count), 0);
        check("midrst_err", int'(err), 0);
        check("midrst_level", int'(water_level), 0);
        reset = 1'b1;
        cyc(1);

        // Random switching with occasional resets
        for (int c = 0; c < 6000; c++) begin
            for (int b = 0; b < 6; b++)
                if ($urandom_range(0, 5) == 0) sw[b] = ~sw[b];
            reset = ($urandom_range(0, 799) == 0) ? 1'b0 : 1'b1;
            cyc(1);
        end

        reset = 1'b1;
        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/canal_lock_ctrl.md
CANAL_LOCK_CTRL -- requirements
Module: canal_lock_ctrl

Interface
REQ-001 SHALL have parameter LVL_W, default 12: water-level width, unsigned, units of 1/16 ft.
REQ-002 SHALL have parameter INNER_LVL, default 80: inner (high) water level, 5.0 ft.
REQ-003 SHALL have parameter OUTER_LVL, default 0: outer (low) water level.
REQ-004 SHALL have parameter TOL, default 5: door-openable tolerance, 0.3125 ft.
REQ-005 SHALL have parameters FILL_STEP, default 10, and DRAIN_STEP, default 11: level change per request.
REQ-006 SHALL have parameters ARR_DELAY, default 5, and DEPT_DELAY, default 5: durations in ticks.
REQ-007 SHALL have parameter TICK_DIV, default 1024: clk cycles per tick.
REQ-008 SHALL have parameter QDEPTH, default 2: depth of the pending-arrival queue, minimum 1.
REQ-009 SHALL have port clk, input, 1 bit: the single clock.
REQ-010 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-011 SHALL have ports inner_arr_sw and outer_arr_sw, inputs, 1 bit: gondola arrival switches, level signals.
REQ-012 SHALL have ports inner_door_sw and outer_door_sw, inputs, 1 bit: door-open requests.
REQ-013 SHALL have ports fill_sw and drain_sw, inputs, 1 bit: water-level requests.
REQ-014 SHALL have port water_level, output, LVL_W bits, plus outputs inner_openable and outer_openable, 1 bit each.
REQ-015 SHALL have outputs inner_gondola_led and outer_gondola_led, 1 bit each.
REQ-016 SHALL have outputs state, 3 bits; q_count, $clog2(QDEPTH+1) bits; and err, 1 bit, a one-cycle pulse.

Function
REQ-017 SHALL act on the rising edge of each switch input only, detected against its registered previous value.
REQ-018 SHALL change water_level on a fill edge to min(level+FILL_STEP, INNER_LVL) and on a drain edge to max(level-DRAIN_STEP, OUTER_LVL); simultaneous fill and drain edges leave the level unchanged.
REQ-019 SHALL compute arithmetic one bit wider than LVL_W, so saturation is exact with no wrap-around.
REQ-020 SHALL drive combinationally outer_openable = (level < OUTER_LVL+TOL) and inner_openable = (level > INNER_LVL-TOL).
REQ-021 SHALL implement the FSM states IDLE=0, ARRIVING=1, POUND=2, DEPARTING=3 and latch the gondola direction (IN = from outer, OUT = from inner).
REQ-022 SHALL, in IDLE on an arrival edge (or a queue entry present), load dir, clear the tick counter, light the arrival-side LED, and move to ARRIVING; outer_arr_sw takes priority if both edges occur together, and the other edge is enqueued.
REQ-023 SHALL, in ARRIVING, when an arrival-side door edge occurs with count >= ARR_DELAY and that side openable, clear the arrival LED and move to POUND; otherwise the door edge SHALL pulse err.
REQ-024 SHALL, in POUND, when a departure-side door edge occurs with that side openable, light the departure LED, clear the counter, and move to DEPARTING; otherwise the door edge SHALL pulse err.
REQ-025 SHALL, in DEPARTING, when count >= DEPT_DELAY, clear the LED and go to IDLE (or directly to ARRIVING if the queue is non-empty, popping in the same cycle).
REQ-026 SHALL increment the tick counter once per tick, saturating at max(ARR_DELAY, DEPT_DELAY).
REQ-027 SHALL enqueue arrival edges that occur outside IDLE (FIFO); an arrival edge when the queue is full SHALL be dropped and SHALL pulse err.
REQ-028 SHALL ignore door edges in IDLE, silently.

Reset
REQ-029 SHALL, while reset=0 at a clk edge, set water_level=OUTER_LVL, state=IDLE, both LEDs=0, err=0, queue empty, counter=0, tick divider=0, and edge registers=current inputs.
REQ-030 SHALL, when reset occurs mid-operation, abandon the gondola in progress and all queued arrivals, with no err pulse.

Configuration
REQ-031 SHALL, with LOCK_AUTO_PUMP_EN defined, ignore fill and drain edges in POUND and move the level one step per tick toward the departure-side level (saturating).
REQ-032 SHALL, without LOCK_AUTO_PUMP_EN, move the level only on fill and drain edges in all states.

Structure
REQ-033 SHALL place the state enum, the direction typedef, and the default level/step constants in package lock_pkg.
REQ-034 SHALL place the level register, saturation, openable logic, and auto-pump logic in sub-module lock_water_level.

Verification (defaults, TICK_DIV=4)
REQ-035 SHALL cover: reset low for 2 cycles -> water_level=0, outer_openable=1, inner_openable=0, state=0, LEDs=0.
REQ-036 SHALL cover: 8 fill edges -> level 10,20,...,80, saturating at 80; inner_openable=1 from level 80 (>75); 1 drain edge -> 69, inner_openable=0.
REQ-037 SHALL cover: outer_arr edge, outer_door edge at tick 3 -> err pulse, state stays 1; outer_door edge at tick 5 with level 0 -> state 2, outer LED=0.
REQ-038 SHALL cover: in POUND, fill to 80, inner_door edge -> state 3, inner LED=1; after 5 ticks -> state 0, LED=0.
REQ-039 SHALL cover: during POUND, 3 inner_arr edges -> q_count 1, then 2, then a third edge gives err with q_count 2; after DEPARTING completes -> state 1 directly, q_count 1.
REQ-040 SHALL cover: simultaneous fill and drain edges at level 40 -> level stays 40; reset low in state 2 -> state 0, q_count 0.
